// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_bus_arbiter: FSM states, GRANT codes and default widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_D  = 3'd1,
    GNT_I  = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_I    = 2'b01,
    GRANT_D    = 2'b10
  } grant_t;

  // Owner of the memory port as seen from outside; DONE still belongs to its requester.
  function automatic grant_t owner_of(state_t s);
    case (s)
      GNT_D, DONE_D: return GRANT_D;
      GNT_I, DONE_I: return GRANT_I;
      default:       return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration policy: picks the winner among pending requesters.
// With both pending, the requester that did not own the port last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       d_req,
  input  logic       i_req,
  input  logic [1:0] last_owner,
  output logic [1:0] win
);

  always_comb begin
    win = GRANT_NONE;
    if (d_req && i_req) win = (last_owner == GRANT_D) ? GRANT_I : GRANT_D;
    else if (d_req)     win = GRANT_D;
    else if (i_req)     win = GRANT_I;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the main-memory port between the I-fetch (read-only) and data (read/write) requesters.
// Define ROUND_ROBIN_EN to alternate winners on simultaneous requests instead of fixed D-over-I.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        GRANT
);

  state_t     state, state_nxt;
  logic       issued;
  logic       d_req, i_req, in_gnt, cmpl;
  logic [1:0] last_owner, win;

  assign d_req  = D_READ | D_WRITE;
  assign i_req  = I_READ;
  assign in_gnt = (state == GNT_D) || (state == GNT_I);
  // Memory may drop busywait before it has seen the strobe, so the first GNT cycle never completes.
  assign cmpl   = in_gnt & issued & ~MEM_BUSYWAIT;

  mem_arb_pick u_pick (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_owner (last_owner),
    .win        (win)
  );

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge CLK) begin
    if (RESET)                last_owner <= GRANT_I;
    else if (state == DONE_D) last_owner <= GRANT_D;
    else if (state == DONE_I) last_owner <= GRANT_I;
  end
`else
  assign last_owner = GRANT_I;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (win == GRANT_D)      state_nxt = GNT_D;
        else if (win == GRANT_I) state_nxt = GNT_I;
      end
      GNT_D:          if (cmpl) state_nxt = DONE_D;
      GNT_I:          if (cmpl) state_nxt = DONE_I;
      DONE_D, DONE_I: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    GRANT      = owner_of(state);
    D_BUSYWAIT = d_req & (state != DONE_D);
    I_BUSYWAIT = i_req & (state != DONE_I);
  end

  // Memory-side command registers are loaded once on grant; requester changes are not re-sampled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      D_READDATA    <= '0;
      I_READDATA    <= '0;
      issued        <= 1'b0;
    end else if (state == IDLE && state_nxt == GNT_D) begin
      MEM_READ      <= ~D_WRITE;
      MEM_WRITE     <= D_WRITE;
      MEM_ADDRESS   <= D_ADDRESS;
      MEM_WRITEDATA <= D_WRITEDATA;
      issued        <= 1'b0;
    end else if (state == IDLE && state_nxt == GNT_I) begin
      MEM_READ      <= 1'b1;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= I_ADDRESS;
      issued        <= 1'b0;
    end else if (cmpl) begin
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;
      if (MEM_READ) begin
        if (state == GNT_D) D_READDATA <= MEM_READDATA;
        else                I_READDATA <= MEM_READDATA;
      end
    end else if (in_gnt) begin
      issued <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_bus_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          D_READ, D_WRITE, D_BUSYWAIT;
  logic [AW-1:0] D_ADDRESS;
  logic [DW-1:0] D_WRITEDATA, D_READDATA;
  logic          I_READ, I_BUSYWAIT;
  logic [AW-1:0] I_ADDRESS;
  logic [DW-1:0] I_READDATA;
  logic          MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA, MEM_READDATA;
  logic [1:0]    GRANT;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] tbmem [64];

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(a));
  endfunction

  // Memory: busy for the first mem_lat cycles of each strobe burst.
  assign MEM_READDATA = tbmem[MEM_ADDRESS];
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat);
  always @(posedge CLK) begin
    mem_cnt <= (MEM_READ | MEM_WRITE) ? mem_cnt + 1 : 0;
    if (RESET) for (int a = 0; a < 64; a++) tbmem[a] <= init_val(a);
    else if (MEM_WRITE && !MEM_BUSYWAIT) tbmem[MEM_ADDRESS] <= MEM_WRITEDATA;
  end

  // Model: phase 0 idle, 1 granted, 2 done; owner 1=I, 2=D. A grant lasts max(2, lat+1) cycles.
  int m_phase = 0, m_owner = 0, m_last = 1, m_cnt = 0;
  bit m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_dread = '0, m_iread = '0;
  logic [DW-1:0] mm [64];

  function automatic int model_pick(input bit d, input bit i, input int last);
    if (d && i) return (RR && last == 2) ? 1 : 2;
    if (d) return 2;
    if (i) return 1;
    return 0;
  endfunction

  function automatic int grant_len(input int lat);
    return (lat + 1 > 2) ? lat + 1 : 2;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_phase <= 0; m_owner <= 0; m_last <= 1; m_cnt <= 0; m_write <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_dread <= '0; m_iread <= '0;
      for (int a = 0; a < 64; a++) mm[a] <= init_val(a);
    end else if (m_phase == 0) begin
      if (model_pick(D_READ | D_WRITE, I_READ, m_last) == 2) begin
        m_phase <= 1; m_owner <= 2; m_cnt <= 0;
        m_write <= D_WRITE; m_addr <= D_ADDRESS; m_wdata <= D_WRITEDATA;
      end else if (model_pick(D_READ | D_WRITE, I_READ, m_last) == 1) begin
        m_phase <= 1; m_owner <= 1; m_cnt <= 0;
        m_write <= 1'b0; m_addr <= I_ADDRESS;
      end
    end else if (m_phase == 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= grant_len(mem_lat)) begin
        m_phase <= 2;
        if (m_write)           mm[m_addr] <= m_wdata;
        else if (m_owner == 2) m_dread <= mm[m_addr];
        else                   m_iread <= mm[m_addr];
      end
    end else begin
      m_phase <= 0; m_last <= m_owner; m_owner <= 0;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (chk_en) begin
    cmp("MEM_READ",    32'(MEM_READ),    32'(m_phase == 1 && !m_write));
    cmp("MEM_WRITE",   32'(MEM_WRITE),   32'(m_phase == 1 && m_write));
    cmp("MEM_ADDRESS", 32'(MEM_ADDRESS), 32'(m_addr));
    if (m_phase == 1 && m_write) cmp("MEM_WRITEDATA", MEM_WRITEDATA, m_wdata);
    cmp("GRANT",       32'(GRANT),       (m_phase != 0) ? 32'(m_owner) : 32'd0);
    cmp("D_BUSYWAIT",  32'(D_BUSYWAIT),  32'((D_READ | D_WRITE) && !(m_phase == 2 && m_owner == 2)));
    cmp("I_BUSYWAIT",  32'(I_BUSYWAIT),  32'(I_READ && !(m_phase == 2 && m_owner == 1)));
    cmp("D_READDATA",  D_READDATA, m_dread);
    cmp("I_READDATA",  I_READDATA, m_iread);
  end

  logic [1:0] prev_g = 2'b00;
  logic [1:0] gq [$];
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;
  int rd_c, wr_c, i_busy, i_low;

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Runs until the port is idle with nothing pending; requesters drop their request in DONE.
  task automatic run_idle(input string nm);
    rd_c = 0; wr_c = 0; i_busy = 0; i_low = 0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (MEM_READ) rd_c++;
      if (MEM_WRITE) begin wr_c++; last_wa = MEM_ADDRESS; last_wd = MEM_WRITEDATA; end
      if (GRANT != 2'b00 && GRANT != prev_g) gq.push_back(GRANT);
      prev_g = GRANT;
      if (I_READ) begin
        if (I_BUSYWAIT) i_busy++;
        else begin i_low++; I_READ = 1'b0; end
      end
      if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin D_READ = 1'b0; D_WRITE = 1'b0; end
      if (GRANT == 2'b00 && !I_READ && !D_READ && !D_WRITE) return;
    end
    n_cmp++; n_err++;
    $display("FAIL %s: timeout, got no idle within 200 cycles, expected idle", nm);
  endtask

  initial begin
    RESET = 1'b1; D_READ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
    I_READ = 1'b0; I_ADDRESS = '0; mem_lat = 2;

    // 1: reset held two edges with D_READ pending
    step(1); chk_en = 1'b1; step(1);
    cmp("rst_mem_read",  32'(MEM_READ), 32'd0);
    cmp("rst_mem_addr",  32'(MEM_ADDRESS), 32'd0);
    cmp("rst_d_busy",    32'(D_BUSYWAIT), 32'd1);
    cmp("rst_grant",     32'(GRANT), 32'd0);
    cmp("rst_i_rdata",   I_READDATA, 32'd0);
    RESET = 1'b0;
    step(1);
    cmp("rel_grant_d",   32'(GRANT), 32'd2);
    run_idle("t1");
    cmp("t1_d_rdata",    D_READDATA, 32'hA5A50000);

    // 2: I read, 5 busy cycles
    mem_lat = 5; I_ADDRESS = 6'h05; I_READ = 1'b1;
    run_idle("t2");
    cmp("t2_rd_cycles",  32'(rd_c), 32'd6);
    cmp("t2_i_busy",     32'(i_busy), 32'd6);
    cmp("t2_i_low",      32'(i_low), 32'd1);
    cmp("t2_i_rdata",    I_READDATA, 32'hDEADBEEF);

    // 3: D write to the top address
    mem_lat = 1; D_WRITE = 1'b1; D_ADDRESS = 6'h3F; D_WRITEDATA = 32'h12345678;
    run_idle("t3");
    cmp("t3_wr_cycles",  32'(wr_c), 32'd2);
    cmp("t3_rd_cycles",  32'(rd_c), 32'd0);
    cmp("t3_wr_addr",    32'(last_wa), 32'h3F);
    cmp("t3_wr_data",    last_wd, 32'h12345678);
    cmp("t3_d_rdata",    D_READDATA, 32'hA5A50000);

    // 4: simultaneous requests, two rounds
    mem_lat = 0; gq.delete();
    for (int r = 0; r < 2; r++) begin
      D_READ = 1'b1; D_ADDRESS = 6'h3F; I_READ = 1'b1; I_ADDRESS = 6'h05;
      run_idle("t4");
    end
    cmp("t4_n_grants",   32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      cmp("t4_g0", 32'(gq[0]), RR ? 32'd1 : 32'd2);
      cmp("t4_g1", 32'(gq[1]), RR ? 32'd2 : 32'd1);
      cmp("t4_g2", 32'(gq[2]), RR ? 32'd1 : 32'd2);
      cmp("t4_g3", 32'(gq[3]), RR ? 32'd2 : 32'd1);
    end
    cmp("t4_d_rdata",    D_READDATA, 32'h12345678);
    cmp("t4_i_rdata",    I_READDATA, 32'hDEADBEEF);

    // 5: reset in the third busy cycle of an I grant
    mem_lat = 8; I_ADDRESS = 6'h07; I_READ = 1'b1;
    step(3);
    cmp("t5_pre_grant",  32'(GRANT), 32'd1);
    RESET = 1'b1;
    step(1);
    cmp("t5_mem_read",   32'(MEM_READ), 32'd0);
    cmp("t5_grant",      32'(GRANT), 32'd0);
    cmp("t5_i_rdata",    I_READDATA, 32'd0);
    RESET = 1'b0;
    run_idle("t5");
    cmp("t5_rd_cycles",  32'(rd_c), 32'd9);
    cmp("t5_i_rdata2",   I_READDATA, 32'hA5A50007);

    // 6: zero-wait memory, read+write together is a write
    mem_lat = 0; D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 6'h0A; D_WRITEDATA = 32'hCAFEF00D;
    run_idle("t6w");
    cmp("t6_wr_cycles",  32'(wr_c), 32'd2);
    cmp("t6_rd_cycles",  32'(rd_c), 32'd0);
    D_READ = 1'b1; D_ADDRESS = 6'h0A;
    run_idle("t6r");
    cmp("t6_rd2_cycles", 32'(rd_c), 32'd2);
    cmp("t6_d_rdata",    D_READDATA, 32'hCAFEF00D);

    // 7: request dropped mid-grant still completes
    mem_lat = 3; I_ADDRESS = 6'h05; I_READ = 1'b1;
    step(2);
    I_READ = 1'b0;
    run_idle("t7");
    cmp("t7_i_rdata",    I_READDATA, 32'hDEADBEEF);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single main-memory port between the instruction-fetch requester (read-only) and the data requester (read/write). Sits between the I/D caches and main memory. Serialises accesses and drives per-requester busywait. Returns read data through registered per-requester outputs.

Parameters:
ADDR_W, 6, memory block address width
DATA_W, 32, memory block data width

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
D_READ  in  1  data read request
D_WRITE  in  1  data write request
D_ADDRESS  in  ADDR_W  data block address
D_WRITEDATA  in  DATA_W  data write block
D_READDATA  out  DATA_W  registered data read block
D_BUSYWAIT  out  1  data requester stall
I_READ  in  1  instruction read request
I_ADDRESS  in  ADDR_W  instruction block address
I_READDATA  out  DATA_W  registered instruction block
I_BUSYWAIT  out  1  instruction requester stall
MEM_READ  out  1  memory read strobe
MEM_WRITE  out  1  memory write strobe
MEM_ADDRESS  out  ADDR_W  memory block address
MEM_WRITEDATA  out  DATA_W  memory write block
MEM_READDATA  in  DATA_W  memory read block
MEM_BUSYWAIT  in  1  memory busy
GRANT  out  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- States: IDLE, GNT_D, GNT_I, DONE_D, DONE_I.
- Reset (sync, RESET=1 at edge): state=IDLE, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, D_READDATA=I_READDATA=0, GRANT=00, issued flag=0. Reset mid-transfer abandons it; no data is returned. The requester re-arbitrates after reset.
- IDLE: sample requests. D_READ|D_WRITE goes to GNT_D; otherwise I_READ goes to GNT_I; otherwise stay. On a simultaneous request, D wins (fixed priority).
- GNT_x: register MEM_* from the granted requester on entry.
  - D_WRITE=1 takes precedence over D_READ (both high is illegal; treated as write).
  - Strobes stay high throughout GNT_x.
  - Completion: first edge with MEM_BUSYWAIT=0 and issued=1. issued is set at the end of the first GNT cycle, so there is a minimum of 2 cycles in GNT.
  - On completion: latch MEM_READDATA into x_READDATA (reads only), drop strobes, go to DONE_x.
- DONE_x: one cycle. Strobes low, giving memory a turnaround. x_BUSYWAIT=0 during this cycle. The requester must drop or change its request by the next edge. The next state is IDLE, and requester x is ignored in the arbitration decision for this cycle.
- x_BUSYWAIT (combinational) = (x request active) & ~(state==DONE_x). It goes high in the same cycle a request appears; this includes a losing requester.
- GRANT is combinational from state: GNT_x/DONE_x give x; otherwise 00.
- Requester address and data must be stable while x_BUSYWAIT=1. Changes are not re-sampled after entry to GNT_x.
- Latency, no contention: request at cycle 0, GNT at edge 1, memory with N busy cycles; DONE at edge 1+max(2,N+1), IDLE one cycle later.
- A requester that drops its request during GNT_x does not abort the transfer; the transfer completes and the data is latched.

Optional Feature:
ROUND_ROBIN_EN
- Defined: a last_owner flip-flop (reset to I) is updated on each DONE_x. On simultaneous requests in IDLE, the requester that is not last_owner wins.
- Undefined: fixed D-over-I priority. last_owner is not instantiated.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants (IDLE=0, GNT_D=1, GNT_I=2, DONE_D=3, DONE_I=4; 3 bits)
  - GRANT codes
  - default ADDR_W/DATA_W
- One natural sub-module: mem_arb_pick. It is combinational and takes d_req, i_req and last_owner (tied to I when the macro is off), returning the winner. It keeps the priority policy isolated for the optional feature.

Test Plan:
1. RESET=1 for 2 edges while D_READ=1 -> all outputs 0 except D_BUSYWAIT=1, GRANT=00; release -> GNT_D next edge.
2. I_READ only, addr 6'h05; memory returns 32'hDEADBEEF after 5 busy cycles -> MEM_READ high 6 cycles, I_READDATA=32'hDEADBEEF, I_BUSYWAIT low for exactly 1 cycle.
3. D_WRITE addr 6'h3F, data 32'h12345678 -> MEM_WRITE=1, MEM_ADDRESS=6'h3F, MEM_WRITEDATA=32'h12345678; D_READDATA unchanged.
4. D_READ and I_READ in same cycle -> D served first, I_BUSYWAIT held high throughout; I granted after D's DONE+IDLE. With ROUND_ROBIN_EN, repeat back-to-back -> grants alternate I,D,I,D.
5. RESET asserted during GNT_I busy cycle 3 -> next edge MEM_READ=0, state IDLE, I_READDATA still 0.
6. MEM_BUSYWAIT=0 constantly (zero-wait memory) -> GNT lasts exactly 2 cycles; D_READ and D_WRITE both high -> write issued.
